systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

- Edge feeder for the systolic MAC array.
- Buffers one N×N operand matrix, one N-lane vector per handshake.
- Replays the matrix as a diagonally skewed, zero-padded wavefront: lane i is delayed i cycles.
- Two instances per array: one drives the operand1 edge (rows of A), one drives the operand2 edge (columns of B). Each lane connects directly to the edge PE's operand input.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one operand element
- N, 4, array dimension; number of lanes and number of buffered vectors (N ≥ 2)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  load_data holds a valid vector
- load_ready  output  1  feeder can accept a vector this cycle
- load_data  input  N*DATA_WIDTH  vector k; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- start  input  1  begin streaming the buffered matrix
- skew_out  output  N*DATA_WIDTH  skewed operand lanes, same lane packing as load_data
- skew_valid  output  1  high on every stream cycle
- busy  output  1  high in READY and STREAM states
- done  output  1  one-cycle pulse after the last stream cycle

## Operation
- States: LOAD, READY, STREAM, DONE.
- LOAD:
  - load_ready = 1.
  - A transfer occurs when load_valid && load_ready at a rising edge. The vector is written to buffer[vcnt] and vcnt increments.
  - On the Nth transfer: state → READY, vcnt → 0.
- READY:
  - load_ready = 0; load_valid is ignored.
  - start = 1 at an edge: state → STREAM, k → 0.
- STREAM:
  - Stream length L = 2N−1 cycles.
  - In stream cycle k, lane i = buffer[k−i][i] if 0 ≤ k−i ≤ N−1, else 0.
  - k increments each edge. After cycle k = L−1: state → DONE.
- DONE: lasts one cycle with done = 1, then state → LOAD.
- start is ignored in LOAD, STREAM and DONE. It is not queued.
- No arithmetic is performed: elements pass through bit-exact, and padding is all-zero.
- Buffer contents are not reset. Outputs never expose buffer contents outside STREAM.

## Timing
- Reset values, all outputs: load_ready = 1 (state LOAD, vcnt = 0); skew_out = 0; skew_valid = 0; busy = 0; done = 0.
- skew_out and skew_valid are registered.
  - If start is sampled at edge E0, stream cycle k = 0 is visible during the cycle after E0, i.e. 1-cycle latency.
  - Cycle k = L−1 is visible after edge E0+L−1.
  - done is high after edge E0+L.
  - load_ready returns after edge E0+L+1.
- skew_out = 0 whenever skew_valid = 0.
- load_valid held high in LOAD: exactly N consecutive transfers, then load_ready drops. The (N+1)th vector is not accepted.
- load_valid and start high in the same cycle in LOAD: the load is accepted, start is ignored.
- Reset asserted in any state: next edge returns to LOAD, vcnt = 0, all outputs at reset values. A partially loaded or partially streamed matrix is discarded.

## Configuration
- Macro: SKEW_FEEDER_FLUSH_EN.
- Defined: N−1 extra all-zero cycles, with skew_valid = 1, are appended to the stream, so L = 3N−2. These cycles push the last operands through the far PEs so the array needs no external zero insertion.
- Undefined: L = 2N−1. done follows the last data cycle directly.

## Test plan
All scenarios use N = 4, DATA_WIDTH = 8, and load vector k with lane i = 16·i + k + 1.
- Reset then load: 4 transfers with load_valid held high → load_ready falls after the 4th edge, busy = 1, skew_out = 0, skew_valid = 0.
- Skew pattern (flush undefined), start pulsed:
  - k=0: lanes {1,0,0,0}
  - k=3: {4,19,34,49}
  - k=6: {0,0,0,52}
  - 7 valid cycles, then done for 1 cycle, then load_ready = 1.
- Flush defined: same stimulus → k=7..9 give skew_out = 0 with skew_valid = 1. done is raised on the 11th cycle after the start edge.
- Ignored inputs:
  - start pulsed during LOAD after 2 transfers → no stream.
  - load_valid high during STREAM → buffer unchanged; a second run reproduces identical output.
- Reset at stream k=2 → next cycle: skew_valid = 0, skew_out = 0, load_ready = 1. A fresh 4-vector load and start stream correctly.
- Back-to-back: done, then immediate reload with new values, then start → new stream, no residue from the previous matrix.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//
// Edge feeder for a systolic MAC array. Buffers one N x N operand matrix,
// loaded one N-lane vector per handshake, then replays it as a diagonally
// skewed, zero-padded wavefront in which lane i lags lane 0 by i cycles.
// Elements pass through bit-exact; padding is all-zero.
//
// Build option:
//   SKEW_FEEDER_FLUSH_EN  when defined, N-1 all-zero cycles (skew_valid = 1)
//                         are appended to each stream so the far PEs are
//                         flushed without external zero insertion.
//                         Stream length is 3N-2 instead of 2N-1.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   load_valid  load_data carries a valid vector
//   load_ready  feeder accepts a vector this cycle (LOAD state)
//   load_data   vector k; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   start       begin streaming the buffered matrix (honoured in READY only)
//   skew_out    registered skewed lanes, same packing as load_data
//   skew_valid  registered, high on every stream cycle
//   busy        high in READY and STREAM
//   done        one-cycle pulse after the last stream cycle
//
// state  | meaning
// -------+--------------------------------------------------------
// LOAD   | accepting vectors; vcnt counts transfers 0..N-1
// READY  | matrix complete, waiting for start
// STREAM | emitting wavefront cycle k = 0..L-1
// DONE   | single cycle, done asserted, then back to LOAD

module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [N*DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  output logic [N*DATA_WIDTH-1:0] skew_out,
  output logic                  skew_valid,
  output logic                  busy,
  output logic                  done
);

`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int L = 3*N - 2;
`else
  localparam int L = 2*N - 1;
`endif

  localparam int VC_W = (N > 1) ? $clog2(N) : 1;
  // Wide enough for k+1 at the last stream cycle and for the diagonal offset.
  localparam int K_W  = $clog2(3*N);
  localparam int VW   = N*DATA_WIDTH;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [VC_W-1:0] vcnt, vcnt_nxt;
  logic [K_W-1:0]  k, k_nxt;
  logic [VW-1:0]   skew_nxt;
  logic            valid_nxt;
  logic            done_nxt;

  // Stream cycle whose lanes are being prepared for the next edge.
  logic [K_W-1:0]  k_sel;
  logic [K_W-1:0]  diff;
  logic [VW-1:0]   lanes;

  // Operand storage; contents deliberately not reset.
  logic [VW-1:0]   buffer [N];

  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && load_valid) begin
      buffer[vcnt] <= load_data;
    end
  end

  // Lane i of stream cycle k reads row (k - i) when that row exists.
  always_comb begin
    lanes = '0;
    diff  = '0;
    for (int i = 0; i < N; i++) begin
      diff = k_sel - K_W'(i);
      if (k_sel >= K_W'(i) && diff < K_W'(N)) begin
        lanes[i*DATA_WIDTH +: DATA_WIDTH] = buffer[diff[VC_W-1:0]][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign k_sel = (state == STREAM) ? (k + K_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      vcnt       <= '0;
      k          <= '0;
      skew_out   <= '0;
      skew_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      vcnt       <= vcnt_nxt;
      k          <= k_nxt;
      skew_out   <= skew_nxt;
      skew_valid <= valid_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vcnt_nxt  = vcnt;
    k_nxt     = k;
    skew_nxt  = '0;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;

    unique case (state)
      LOAD: begin
        // start is not looked at here; a simultaneous load wins.
        if (load_valid) begin
          if (vcnt == VC_W'(N-1)) begin
            vcnt_nxt  = '0;
            state_nxt = READY;
          end else begin
            vcnt_nxt = vcnt + VC_W'(1);
          end
        end
      end
      READY: begin
        if (start) begin
          state_nxt = STREAM;
          k_nxt     = '0;
          valid_nxt = 1'b1;
          skew_nxt  = lanes;
        end
      end
      STREAM: begin
        if (k == K_W'(L-1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          k_nxt     = k + K_W'(1);
          valid_nxt = 1'b1;
          skew_nxt  = lanes;
        end
      end
      DONE: begin
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  assign load_ready = (state == LOAD);
  assign busy       = (state == READY) || (state == STREAM);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int L = 10;
`else
  localparam int L = 7;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        start;
  logic [31:0] skew_out;
  logic        skew_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic        exp_valid;
    logic [31:0] exp_out;
  } stream_vec_t;

  stream_vec_t tbl [10];

  systolic_skew_feeder #(.DATA_WIDTH(8), .N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .skew_out   (skew_out),
    .skew_valid (skew_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load vector k of a matrix: lane i = base + 16*i + k + 1.
  function automatic logic [31:0] vec(input logic [7:0] base, input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = base + 8'(16*i + k + 1);
    return v;
  endfunction

  // Expected wavefront lanes of stream cycle k.
  function automatic logic [31:0] model(input logic [7:0] base, input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (k - i >= 0 && k - i <= 3) v[i*8 +: 8] = base + 8'(16*i + (k - i) + 1);
    return v;
  endfunction

  task automatic load_matrix(input logic [7:0] base);
    load_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load_data = vec(base, k);
      check("load_ready_during_load", {31'b0, load_ready}, 32'd1);
      tick();
    end
    load_valid = 1'b0;
    load_data  = '0;
    check("load_ready_after_4", {31'b0, load_ready}, 32'd0);
    check("busy_after_load", {31'b0, busy}, 32'd1);
    check("skew_valid_ready", {31'b0, skew_valid}, 32'd0);
    check("skew_out_ready", skew_out, 32'd0);
  endtask

  task automatic run_stream(input logic [7:0] base, input bit use_tbl, input bit hold_load);
    logic [31:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (hold_load) begin
      load_valid = 1'b1;
      load_data  = 32'hDEADBEEF;
    end
    for (int k = 0; k < L; k++) begin
      exp = use_tbl ? tbl[k].exp_out : model(base, k);
      check($sformatf("skew_valid_k%0d", k), {31'b0, skew_valid},
            use_tbl ? {31'b0, tbl[k].exp_valid} : 32'd1);
      check($sformatf("skew_out_k%0d", k), skew_out, exp);
      check($sformatf("busy_k%0d", k), {31'b0, busy}, 32'd1);
      if (k < L - 1) tick();
    end
    load_valid = 1'b0;
    load_data  = '0;
    tick();
    check("done_pulse", {31'b0, done}, 32'd1);
    check("valid_in_done", {31'b0, skew_valid}, 32'd0);
    check("out_in_done", skew_out, 32'd0);
    check("ready_in_done", {31'b0, load_ready}, 32'd0);
    tick();
    check("done_cleared", {31'b0, done}, 32'd0);
    check("ready_after_done", {31'b0, load_ready}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{0, 1'b1, 32'h00000001};
    tbl[1] = '{1, 1'b1, 32'h00001102};
    tbl[2] = '{2, 1'b1, 32'h00211203};
    tbl[3] = '{3, 1'b1, 32'h31221304};
    tbl[4] = '{4, 1'b1, 32'h32231400};
    tbl[5] = '{5, 1'b1, 32'h33240000};
    tbl[6] = '{6, 1'b1, 32'h34000000};
    tbl[7] = '{7, 1'b1, 32'h00000000};
    tbl[8] = '{8, 1'b1, 32'h00000000};
    tbl[9] = '{9, 1'b1, 32'h00000000};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_skew_valid", {31'b0, skew_valid}, 32'd0);
    check("rst_skew_out", skew_out, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // Basic load with load_valid held through a fifth cycle: the extra
    // vector must not be taken.
    load_matrix(8'h00);
    load_valid = 1'b1;
    load_data  = 32'hFFFFFFFF;
    tick();
    load_valid = 1'b0;
    load_data  = '0;
    check("extra_vec_ready", {31'b0, load_ready}, 32'd0);
    run_stream(8'h00, 1'b1, 1'b0);

    // start pulsed mid-load is ignored; start together with a load too.
    load_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_data = vec(8'h00, k);
      tick();
    end
    load_valid = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("mid_load_start_valid", {31'b0, skew_valid}, 32'd0);
    check("mid_load_start_busy", {31'b0, busy}, 32'd0);
    check("mid_load_start_ready", {31'b0, load_ready}, 32'd1);
    tick();
    check("mid_load_no_stream", {31'b0, skew_valid}, 32'd0);
    load_valid = 1'b1;
    start      = 1'b1;
    load_data  = vec(8'h00, 2);
    tick();
    start = 1'b0;
    check("start_with_load_valid", {31'b0, skew_valid}, 32'd0);
    check("start_with_load_ready", {31'b0, load_ready}, 32'd1);
    load_data = vec(8'h00, 3);
    tick();
    load_valid = 1'b0;
    check("fourth_load_ready", {31'b0, load_ready}, 32'd0);
    tick();
    check("ready_wait_valid", {31'b0, skew_valid}, 32'd0);
    // Stream with load_valid held: buffer must be unaffected.
    run_stream(8'h00, 1'b1, 1'b1);
    load_matrix(8'h00);
    run_stream(8'h00, 1'b1, 1'b0);

    // Reset in the middle of a stream.
    load_matrix(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_k2", skew_out, tbl[2].exp_out);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_valid", {31'b0, skew_valid}, 32'd0);
    check("post_reset_out", skew_out, 32'd0);
    check("post_reset_ready", {31'b0, load_ready}, 32'd1);
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    load_matrix(8'h00);
    run_stream(8'h00, 1'b1, 1'b0);

    // Back-to-back: immediate reload with different values.
    load_matrix(8'h80);
    run_stream(8'h80, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
